fru_pla_cfg_ctrl: RTL and testbench

- Configuration controller for the segmented FRU PLA.
- Holds a shadow and an active copy of each output's segment-mux selects and minterm-OR mask, loaded through a valid/ready config port.
- A commit command swaps all dirty shadow entries into the active copy atomically.
- During the swap the PLA outputs are gated off for a drain window, so downstream FRUs never see a half-updated select function.

---
 rtl/fru_pla_cfg_ctrl.sv | 155 +++++++++++++++
 tb/tb_fru_pla_cfg_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fru_pla_cfg_ctrl.sv
// Shadow/active configuration store for the segmented FRU PLA with atomic commit.
// Optional readback port enabled by defining FRU_PLA_CFG_READBACK_EN.
module fru_pla_cfg_ctrl #(
   parameter int INPUT_SIZE   = 2,
   parameter int OUTPUT_SIZE  = 4,
   parameter int SEGMENT_SIZE = 2,
   parameter int DRAIN_CYCLES = 2,
   localparam int SEL_W   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
   localparam int ADDR_W  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1,
   localparam int MASK_W  = 2**SEGMENT_SIZE,
   localparam int MUX_W   = SEGMENT_SIZE*SEL_W,
   localparam int ENTRY_W = MUX_W + MASK_W
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          CfgValid,
   output logic                          CfgReady,
   input  logic                          CfgCommit,
   input  logic [ADDR_W-1:0]             CfgAddr,
   input  logic [ENTRY_W-1:0]            CfgData,
   input  logic                          ErrClr,
   output logic                          CfgErr,
`ifdef FRU_PLA_CFG_READBACK_EN
   input  logic [ADDR_W-1:0]             RdAddr,
   output logic [ENTRY_W-1:0]            RdData,
   output logic                          RdDirty,
`endif
   output logic [OUTPUT_SIZE*MUX_W-1:0]  RegMux,
   output logic [OUTPUT_SIZE*MASK_W-1:0] RegMintermORSelect,
   output logic                          FruEnable,
   output logic [7:0]                    CommitCount,
   output logic                          Busy
);

   typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [ENTRY_W-1:0]     shadow_q [OUTPUT_SIZE];
   logic [ENTRY_W-1:0]     active_q [OUTPUT_SIZE];
   logic [OUTPUT_SIZE-1:0] dirty_q;
   logic                   err_q;
   logic [7:0]             ccnt_q;
   logic                   hs, wr_hs, cm_hs, addr_ok;

   assign FruEnable   = (state_q == IDLE);
   assign CfgReady    = FruEnable;
   assign Busy        = !FruEnable;
   assign CfgErr      = err_q;
   assign CommitCount = ccnt_q;

   assign hs    = CfgValid && CfgReady;
   assign wr_hs = hs && !CfgCommit;
   assign cm_hs = hs && CfgCommit;

   // Range check on the write address without width-mismatched compares.
   always_comb begin
      addr_ok = 1'b0;
      for (int i = 0; i < OUTPUT_SIZE; i++)
         if (CfgAddr == ADDR_W'(i)) addr_ok = 1'b1;
   end

   // Next-state and drain counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (cm_hs && (dirty_q != '0)) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d = SWAP;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = 8'(DRAIN_CYCLES - 1);
               end
            end
         end
         DRAIN: begin
            if (cnt_q == 8'd0) state_d = SWAP;
            else cnt_d = cnt_q - 8'd1;
         end
         SWAP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Shadow writes, dirty tracking and the atomic swap into active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUTPUT_SIZE; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         dirty_q <= '0;
         ccnt_q  <= 8'd0;
      end else if (state_q == SWAP) begin
         for (int i = 0; i < OUTPUT_SIZE; i++)
            if (dirty_q[i]) active_q[i] <= shadow_q[i];
         dirty_q <= '0;
         ccnt_q  <= ccnt_q + 8'd1;
      end else if (wr_hs) begin
         for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (CfgAddr == ADDR_W'(i)) begin
               shadow_q[i] <= CfgData;
               dirty_q[i]  <= 1'b1;
            end
         end
      end
   end

   // Sticky error; a new out-of-range write beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else if (wr_hs && !addr_ok) err_q <= 1'b1;
      else if (ErrClr) err_q <= 1'b0;
   end

   for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_flat
      assign RegMux[g*MUX_W +: MUX_W] =
         active_q[g][ENTRY_W-1:MASK_W];
      assign RegMintermORSelect[g*MASK_W +: MASK_W] =
         active_q[g][MASK_W-1:0];
   end

`ifdef FRU_PLA_CFG_READBACK_EN
   // Registered readback of the active entry and its dirty bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RdData  <= '0;
         RdDirty <= 1'b0;
      end else begin
         RdData  <= '0;
         RdDirty <= 1'b0;
         for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (RdAddr == ADDR_W'(i)) begin
               RdData  <= active_q[i];
               RdDirty <= dirty_q[i];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_fru_pla_cfg_ctrl.sv
// Directed bench for fru_pla_cfg_ctrl: commit latency, last-write-wins,
// pending commands, error flag and reset abort.
module tb_fru_pla_cfg_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic       valid, ready, commit, err_clr, err;
   logic [1:0] addr;
   logic [5:0] data;
   logic [7:0] mux;
   logic [15:0] mask;
   logic       fen, busy;
   logic [7:0] ccnt;

   logic       v3, r3, c3, ec3, e3;
   logic [1:0] a3;
   logic [5:0] d3;
   logic [5:0] mux3;
   logic [11:0] mask3;
   logic       fen3, busy3;
   logic [7:0] ccnt3;

`ifdef FRU_PLA_CFG_READBACK_EN
   logic [1:0] rd_addr = 2'd0;
   logic [5:0] rd_data, rd_data3;
   logic       rd_dirty, rd_dirty3;
`endif

   fru_pla_cfg_ctrl u_dut (
      .clk(clk), .rst_n(rst_n),
      .CfgValid(valid), .CfgReady(ready), .CfgCommit(commit),
      .CfgAddr(addr), .CfgData(data),
      .ErrClr(err_clr), .CfgErr(err),
`ifdef FRU_PLA_CFG_READBACK_EN
      .RdAddr(rd_addr), .RdData(rd_data), .RdDirty(rd_dirty),
`endif
      .RegMux(mux), .RegMintermORSelect(mask),
      .FruEnable(fen), .CommitCount(ccnt), .Busy(busy)
   );

   fru_pla_cfg_ctrl #(.OUTPUT_SIZE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .CfgValid(v3), .CfgReady(r3), .CfgCommit(c3),
      .CfgAddr(a3), .CfgData(d3),
      .ErrClr(ec3), .CfgErr(e3),
`ifdef FRU_PLA_CFG_READBACK_EN
      .RdAddr(rd_addr), .RdData(rd_data3), .RdDirty(rd_dirty3),
`endif
      .RegMux(mux3), .RegMintermORSelect(mask3),
      .FruEnable(fen3), .CommitCount(ccnt3), .Busy(busy3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [5:0] d);
      valid = 1'b1; commit = 1'b0; addr = a; data = d;
      step();
      valid = 1'b0;
   endtask

   task automatic cm();
      valid = 1'b1; commit = 1'b1;
      step();
      valid = 1'b0; commit = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({fen, ready, busy, err} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 1100", {fen, ready, busy, err});
      end
      n_checks++;
      if ({mux, mask, ccnt} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_regs got %h want 0", {mux, mask, ccnt});
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_commit_latency();
      wr(2'd1, 6'b10_1000);
      n_checks++;
      if (mux !== 8'h00 || fen !== 1'b1) begin
         n_fail++;
         $display("FAIL write_no_effect got mux=%h fen=%b want 00 1", mux, fen);
      end
      cm();
      for (int k = 1; k <= 3; k++) begin
         n_checks++;
         if ({fen, ready, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL drain_window T+%0d got %b want 001", k, {fen, ready, busy});
         end
         if (k == 3) begin
            n_checks++;
            if (mux !== 8'h00) begin
               n_fail++;
               $display("FAIL no_early_update got %h want 00", mux);
            end
         end
         step();
      end
      n_checks++;
      if ({fen, mux, mask, ccnt} !== {1'b1, 8'h08, 16'h0080, 8'd1}) begin
         n_fail++;
         $display("FAIL commit1 got fen=%b mux=%h mask=%h cnt=%0d want 1 08 0080 1",
                  fen, mux, mask, ccnt);
      end
   endtask

   task automatic test_last_write_wins();
      wr(2'd0, 6'h05);
      wr(2'd0, 6'h0A);
      cm();
      step(); step(); step();
      n_checks++;
      if ({mux, mask, ccnt} !== {8'h08, 16'h008A, 8'd2}) begin
         n_fail++;
         $display("FAIL last_write got mux=%h mask=%h cnt=%0d want 08 008a 2",
                  mux, mask, ccnt);
      end
   endtask

   task automatic test_empty_commit();
      cm();
      n_checks++;
      if ({fen, ready, busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL empty_commit got %b want 110", {fen, ready, busy});
      end
      step();
      n_checks++;
      if (ccnt !== 8'd2 || fen !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_commit_cnt got cnt=%0d fen=%b want 2 1", ccnt, fen);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      wr(2'd2, 6'h11);
      cm();
      valid = 1'b1; commit = 1'b0; addr = 2'd3; data = 6'h22;
      waited = 0;
      while (!ready && waited < 10) begin
         step();
         waited++;
      end
      n_checks++;
      if (waited !== 3) begin
         n_fail++;
         $display("FAIL pending_wait got %0d cycles want 3", waited);
      end
      n_checks++;
      if ({mux, mask, ccnt} !== {8'h18, 16'h018A, 8'd3}) begin
         n_fail++;
         $display("FAIL commit3 got mux=%h mask=%h cnt=%0d want 18 018a 3",
                  mux, mask, ccnt);
      end
      step();
      valid = 1'b0;
      cm();
      step(); step(); step();
      n_checks++;
      if ({mux, mask, ccnt} !== {8'h98, 16'h218A, 8'd4}) begin
         n_fail++;
         $display("FAIL pending_applied got mux=%h mask=%h cnt=%0d want 98 218a 4",
                  mux, mask, ccnt);
      end
   endtask

   task automatic test_err();
      v3 = 1'b1; c3 = 1'b0; a3 = 2'd3; d3 = 6'h3F;
      step();
      v3 = 1'b0;
      n_checks++;
      if (e3 !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set got %b want 1", e3);
      end
      v3 = 1'b1; c3 = 1'b1;
      step();
      v3 = 1'b0; c3 = 1'b0;
      n_checks++;
      if ({fen3, ccnt3, mux3, mask3} !== {1'b1, 8'd0, 6'h0, 12'h0}) begin
         n_fail++;
         $display("FAIL err_no_shadow got fen=%b cnt=%0d mux=%h mask=%h want 1 0 0 0",
                  fen3, ccnt3, mux3, mask3);
      end
      ec3 = 1'b1;
      step();
      ec3 = 1'b0;
      n_checks++;
      if (e3 !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr got %b want 0", e3);
      end
      ec3 = 1'b1; v3 = 1'b1; a3 = 2'd3;
      step();
      ec3 = 1'b0; v3 = 1'b0;
      n_checks++;
      if (e3 !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set_wins got %b want 1", e3);
      end
   endtask

   task automatic test_reset_abort();
      wr(2'd2, 6'h3F);
      cm();
      n_checks++;
      if (fen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_in_drain got fen=%b want 0", fen);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({fen, ready, busy, mux, mask, ccnt} !== {3'b110, 32'h0}) begin
         n_fail++;
         $display("FAIL abort_reset got fen=%b rdy=%b busy=%b mux=%h mask=%h cnt=%0d",
                  fen, ready, busy, mux, mask, ccnt);
      end
      step();
      rst_n = 1'b1;
      step();
      cm();
      n_checks++;
      if (fen !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_dirty_cleared got fen=%b want 1", fen);
      end
      step(); step(); step();
      n_checks++;
      if ({mux, mask, ccnt} !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_no_update got mux=%h mask=%h cnt=%0d want 0",
                  mux, mask, ccnt);
      end
   endtask

   initial begin
      valid = 1'b0; commit = 1'b0; addr = '0; data = '0; err_clr = 1'b0;
      v3 = 1'b0; c3 = 1'b0; a3 = '0; d3 = '0; ec3 = 1'b0;
      test_reset();
      test_commit_latency();
      test_last_write_wins();
      test_empty_commit();
      test_back_to_back();
      test_err();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
